// File: rtl/wb_pkg.sv
// Shared constants, state encoding and gain saturation helper for the
// white-balance gain calculator.
package wb_pkg;

  localparam int SUM_W      = 48;
  localparam int GAIN_W     = 16;
  localparam int FRAC_W     = 10;
  localparam int DIV_CYCLES = SUM_W + FRAC_W;

  localparam logic [GAIN_W-1:0] UNITY_GAIN = GAIN_W'(1 << FRAC_W);
  localparam logic [GAIN_W-1:0] GAIN_MAX   = '1;
  localparam logic [SUM_W-1:0]  MIN_SUM    = SUM_W'(4096);

  typedef enum logic [1:0] {
    IDLE,
    DIV_R,
    DIV_B,
    UPDATE
  } state_e;

  // Any quotient bit above the gain width means the ratio does not fit.
  function automatic logic [GAIN_W-1:0] sat_gain(input logic [DIV_CYCLES-1:0] q);
    if (|q[DIV_CYCLES-1:GAIN_W]) return GAIN_MAX;
    return q[GAIN_W-1:0];
  endfunction

endpackage

// File: rtl/wb_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The load cycle performs the first iteration, so latency is exactly DVD_W edges.
module wb_div_seq
  import wb_pkg::*;
#(
  parameter int DVD_W = 58,
  parameter int DVS_W = 48
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             last_o,
  output logic [DVD_W-1:0] quot_o
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W:0]   rem_q, rem_d;
  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [DVS_W:0]   cur_rem;
  logic [DVD_W-1:0] cur_dvd;
  logic [DVS_W+1:0] shifted;
  logic [DVS_W:0]   trial;
  logic             ge;

  assign last_o = run_q && (cnt_q == CNT_W'(DVD_W - 1));
  assign busy_o = run_q;
  assign quot_o = dvd_q;

  // Quotient bits enter at the bottom of the dividend register as its bits leave the top.
  always_comb begin
    cur_rem = load_i ? '0 : rem_q;
    cur_dvd = load_i ? dividend_i : dvd_q;
    shifted = {cur_rem, cur_dvd[DVD_W-1]};
    ge      = shifted >= {2'b00, divisor_i};
    trial   = shifted[DVS_W:0] - {1'b0, divisor_i};
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (load_i || run_q) begin
      rem_d = ge ? trial : shifted[DVS_W:0];
      dvd_d = {cur_dvd[DVD_W-2:0], ge};
    end
    if (load_i) begin
      cnt_d = CNT_W'(1);
      run_d = 1'b1;
    end else if (last_o) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q <= '0;
      dvd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/wb_gain_calc.sv
// Per-frame white-balance gains: R and B gains relative to G, computed with
// one shared sequential divider and held stable until the next frame end.
module wb_gain_calc
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              wb_en,
  input  logic [SUM_W-1:0]  sum_r,
  input  logic [SUM_W-1:0]  sum_g,
  input  logic [SUM_W-1:0]  sum_b,
  output logic              busy,
  output logic              done,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_g,
  output logic [GAIN_W-1:0] gain_b
);

  state_e                  state_q, state_d;
  logic [SUM_W-1:0]        sr_q, sr_d, sg_q, sg_d, sb_q, sb_d;
  logic                    wben_q, wben_d;
  logic [GAIN_W-1:0]       rsat_q, rsat_d;
  logic [GAIN_W-1:0]       gain_r_q, gain_r_d, gain_b_q, gain_b_d;
  logic                    done_q, done_d;

  logic                    div_load, div_busy, div_last;
  logic [DIV_CYCLES-1:0]   div_quot;
  logic [SUM_W-1:0]        div_divisor;

  assign div_load    = ((state_q == DIV_R) || (state_q == DIV_B)) && !div_busy;
  assign div_divisor = (state_q == DIV_B) ? sb_q : sr_q;

  wb_div_seq #(
    .DVD_W(DIV_CYCLES),
    .DVS_W(SUM_W)
  ) u_div (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (div_load),
    .dividend_i({sg_q, {FRAC_W{1'b0}}}),
    .divisor_i (div_divisor),
    .busy_o    (div_busy),
    .last_o    (div_last),
    .quot_o    (div_quot)
  );

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign gain_r = gain_r_q;
  assign gain_g = UNITY_GAIN;
  assign gain_b = gain_b_q;

  // The red quotient is still in the divider during the first blue cycle, so grab it then.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    sg_d     = sg_q;
    sb_d     = sb_q;
    wben_d   = wben_q;
    rsat_d   = rsat_q;
    gain_r_d = gain_r_q;
    gain_b_d = gain_b_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = sum_r;
          sg_d    = sum_g;
          sb_d    = sum_b;
          wben_d  = wb_en;
          state_d = DIV_R;
        end
      end
      DIV_R: begin
        if (div_last) state_d = DIV_B;
      end
      DIV_B: begin
        if (div_load) rsat_d = sat_gain(div_quot);
        if (div_last) state_d = UPDATE;
      end
      UPDATE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!wben_q) begin
          gain_r_d = UNITY_GAIN;
          gain_b_d = UNITY_GAIN;
        end else if (sg_q >= MIN_SUM) begin
          gain_r_d = rsat_q;
          gain_b_d = sat_gain(div_quot);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      sg_q     <= '0;
      sb_q     <= '0;
      wben_q   <= 1'b0;
      rsat_q   <= '0;
      gain_r_q <= UNITY_GAIN;
      gain_b_q <= UNITY_GAIN;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      sg_q     <= sg_d;
      sb_q     <= sb_d;
      wben_q   <= wben_d;
      rsat_q   <= rsat_d;
      gain_r_q <= gain_r_d;
      gain_b_q <= gain_b_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_wb_gain_calc.sv
// Directed bench for wb_gain_calc: latency, ratios, saturation, dark frames,
// wb_en bypass, start-while-busy and mid-computation reset.
module tb_wb_gain_calc;

  localparam int LAT = 118;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        wb_en = 1'b1;
  logic [47:0] sum_r = '0, sum_g = '0, sum_b = '0;
  logic        busy, done;
  logic [15:0] gain_r, gain_g, gain_b;

  int testsRun = 0;
  int testsFailed = 0;
  int lat;
  int nDone;

  wb_gain_calc dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .wb_en (wb_en),
    .sum_r (sum_r),
    .sum_g (sum_g),
    .sum_b (sum_b),
    .busy  (busy),
    .done  (done),
    .gain_r(gain_r),
    .gain_g(gain_g),
    .gain_b(gain_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  // Presents the sums with start high for one cycle; returns at the negedge of cycle 1.
  task automatic applyStimulus(input logic [47:0] r, input logic [47:0] g, input logic [47:0] b, input logic en);
    @(negedge clk);
    sum_r = r;
    sum_g = g;
    sum_b = b;
    wb_en = en;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sum_r = '0;
    sum_g = '0;
    sum_b = '0;
  endtask

  // Counts cycles until done; optionally re-pulses start or drops reset at given cycles.
  task automatic waitDone(input int pulseAt, input int resetAt, output int n);
    n = 1;
    while (!done && n < 300) begin
      if (n == resetAt) begin
        rstn = 1'b0;
        return;
      end
      if (n == pulseAt) begin
        sum_r = 48'd10000;
        sum_g = 48'd10000;
        sum_b = 48'd10000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic countDones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic runFrame(input string tag, input logic [47:0] r, input logic [47:0] g,
                          input logic [47:0] b, input logic en,
                          input logic [15:0] expR, input logic [15:0] expB);
    applyStimulus(r, g, b, en);
    checkOutput({tag, " busy"}, busy, 1);
    waitDone(0, 0, lat);
    checkOutput({tag, " latency"}, lat, LAT);
    checkOutput({tag, " gain_r"}, gain_r, expR);
    checkOutput({tag, " gain_b"}, gain_b, expB);
    checkOutput({tag, " gain_g"}, gain_g, 16'd1024);
    @(negedge clk);
    checkOutput({tag, " done width"}, done, 0);
    checkOutput({tag, " idle"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("reset gain_r", gain_r, 16'd1024);
    checkOutput("reset gain_g", gain_g, 16'd1024);
    checkOutput("reset gain_b", gain_b, 16'd1024);
    checkOutput("reset busy", busy, 0);
    countDones(20, nDone);
    checkOutput("reset no done", nDone, 0);

    runFrame("ratio", 48'd5000, 48'd10000, 48'd20000, 1'b1, 16'd2048, 16'd512);
    runFrame("trunc/div0", 48'd3000, 48'd10000, 48'd0, 1'b1, 16'd3413, 16'hFFFF);
    runFrame("sat", 48'd1, 48'h100_0000_0000, 48'h100_0000_0000, 1'b1, 16'hFFFF, 16'd1024);
    runFrame("dark", 48'd50, 48'd100, 48'd200, 1'b1, 16'hFFFF, 16'd1024);
    runFrame("wb_en=0", 48'd5000, 48'd10000, 48'd20000, 1'b0, 16'd1024, 16'd1024);

    applyStimulus(48'd5000, 48'd10000, 48'd2500, 1'b1);
    waitDone(40, 0, lat);
    checkOutput("busy-start latency", lat, LAT);
    checkOutput("busy-start gain_r", gain_r, 16'd2048);
    checkOutput("busy-start gain_b", gain_b, 16'd4096);
    countDones(150, nDone);
    checkOutput("busy-start single done", nDone, 0);

    applyStimulus(48'd2500, 48'd10000, 48'd5000, 1'b1);
    waitDone(0, 70, lat);
    #1;
    checkOutput("abort gain_r", gain_r, 16'd1024);
    checkOutput("abort gain_b", gain_b, 16'd1024);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    countDones(130, nDone);
    checkOutput("abort no done", nDone, 0);
    runFrame("after abort", 48'd2500, 48'd10000, 48'd5000, 1'b1, 16'd4096, 16'd2048);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
